// File: rtl/jtsdram_video_pkg.sv
// Shared definitions for the JTSDRAM per-bank error bar display.
//   COL_FULL / COL_OFF : 4-bit colour levels
//   BAND_H_DEF         : default number of active lines per bank band
//   band_w()           : width of the band index for a given bank count
package jtsdram_video_pkg;

  localparam logic [3:0] COL_FULL   = 4'hF;
  localparam logic [3:0] COL_OFF    = 4'h0;
  localparam int         BAND_H_DEF = 56;

  // clog2 of the bank count, never narrower than one bit so a single-bank
  // build still has a legal index vector.
  function automatic int band_w(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/jtsdram_errcnt.sv
// Per-bank error bookkeeping for the JTSDRAM video bars.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of count, snapshot, sticky and fresh
//   bad        : error level from the bank checker (edge detected here)
//   snap_en    : one-clk strobe at the start of vertical blank
//   snap       : count captured at the last snap_en
//   sticky     : set by any error since the last clear
//   fresh      : count changed since the previous snapshot
//                (only with JTSDRAM_BLINK_EN defined, otherwise tied 0)
module jtsdram_errcnt
  import jtsdram_video_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          bad,
  input  logic          snap_en,
  output logic [CW-1:0] snap,
  output logic          sticky,
  output logic          fresh
);

  localparam logic [CW-1:0] CMAX = '1;

  logic          prev;
  logic [CW-1:0] cnt;
  logic          rise;

  // prev resets low, so a level already high when reset lifts is one error
  assign rise = bad & ~prev;

  // prev keeps tracking bad even through clr, so a level held across a
  // clear is not counted again when clr drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      sticky <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      sticky <= 1'b0;
    end else if (rise) begin
      if (cnt != CMAX) cnt <= cnt + CW'(1);
      sticky <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       snap <= '0;
    else if (clr)     snap <= '0;
    else if (snap_en) snap <= cnt;
  end

`ifdef JTSDRAM_BLINK_EN
  // compared against the old snapshot, before it is overwritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       fresh <= 1'b0;
    else if (clr)     fresh <= 1'b0;
    else if (snap_en) fresh <= (cnt != snap);
  end
`else
  assign fresh = 1'b0;
`endif

endmodule

// File: rtl/jtsdram_video_bars.sv
// Per-bank SDRAM error display for the JTSDRAM tester.
// Each bank gets a horizontal band of BAND_H active lines: a blue separator
// on its first line, then a red bar (length = snapshot count << XSCALE) on a
// green background. Snapshots are taken at every LVBL falling edge, so a
// frame shows the counts as they were when its vertical blank began.
//   clk, rst_n        : clock, asynchronous active-low reset
//   pxl_cen           : pixel clock enable
//   LVBL, LHBL        : vertical / horizontal blank, active low
//   dwnld_busy        : halves every non-zero colour
//   clr               : clears counters, snapshots and sticky flags
//   bad[BANKS]        : per-bank error levels
//   red, green, blue  : registered 4-bit colour
//   err_any           : registered OR of all sticky flags
// Optional macro JTSDRAM_BLINK_EN: a band whose count changed at the last
// snapshot blanks its red segment while frame_cnt[3] is set.
module jtsdram_video_bars
  import jtsdram_video_pkg::*;
#(
  parameter int BANKS  = 4,
  parameter int CW     = 8,
  parameter int BAND_H = BAND_H_DEF,
  parameter int XSCALE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pxl_cen,
  input  logic             LVBL,
  input  logic             LHBL,
  input  logic             dwnld_busy,
  input  logic             clr,
  input  logic [BANKS-1:0] bad,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue,
  output logic             err_any
);

  localparam int              BW        = band_w(BANKS);
  localparam int              LW        = (BAND_H > 1) ? $clog2(BAND_H) : 1;
  localparam logic [BW-1:0]   LAST_BAND = BW'(BANKS - 1);
  localparam logic [LW-1:0]   LAST_LINE = LW'(BAND_H - 1);

  logic             lhbl_l, lvbl_l;
  logic             vb_fall, hb_fall;
  logic [3:0]       frame_cnt;
  logic [BW-1:0]    band;
  logic [LW-1:0]    bline;     // line within the current band
  logic             outside;   // past the last band until next vblank
  logic [8:0]       x;
  logic [BANKS-1:0] sticky, fresh;
  logic [CW-1:0]    snap [BANKS];

  // ---------------------------------------------------------------- banks
  for (genvar i = 0; i < BANKS; i++) begin : g_bank
    jtsdram_errcnt #(.CW(CW)) u_errcnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .bad     (bad[i]),
      .snap_en (vb_fall),
      .snap    (snap[i]),
      .sticky  (sticky[i]),
      .fresh   (fresh[i])
    );
  end

  // -------------------------------------------------------- blank edges
  // The registered copies double as the blanking qualifier for the colour
  // pipeline, so both are tracked every clk rather than on pxl_cen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lhbl_l <= 1'b0;
      lvbl_l <= 1'b0;
    end else begin
      lhbl_l <= LHBL;
      lvbl_l <= LVBL;
    end
  end

  assign vb_fall = lvbl_l & ~LVBL;
  assign hb_fall = lhbl_l & ~LHBL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       frame_cnt <= 4'd0;
    else if (vb_fall) frame_cnt <= frame_cnt + 4'd1;
  end

  // ------------------------------------------------------- line / band
  // The band/line-in-band pair replaces a flat line counter and a divide;
  // once the last band ends the counter parks in 'outside' until vblank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      band    <= '0;
      bline   <= '0;
      outside <= 1'b0;
    end else if (!LVBL) begin
      band    <= '0;
      bline   <= '0;
      outside <= 1'b0;
    end else if (hb_fall && !outside) begin
      if (bline == LAST_LINE) begin
        bline <= '0;
        if (band == LAST_BAND) outside <= 1'b1;
        else                   band    <= band + BW'(1);
      end else begin
        bline <= bline + LW'(1);
      end
    end
  end

  // --------------------------------------------------------------- pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     x <= 9'd0;
    else if (!LHBL)                 x <= 9'd0;
    else if (pxl_cen && x != 9'h1FF) x <= x + 9'd1;
  end

  // -------------------------------------------------------------- colour
  logic [CW-1:0] snap_sel;
  logic [31:0]   bar_len;
  logic          on_bar, blink_off;
  logic [3:0]    r_n, g_n, b_n;

  always_comb begin
    snap_sel  = snap[band];
    bar_len   = 32'(snap_sel) << XSCALE;
    on_bar    = 32'(x) < bar_len;
    // fresh is constant 0 unless the blink feature is built in
    blink_off = fresh[band] & frame_cnt[3];
    r_n       = COL_OFF;
    g_n       = COL_OFF;
    b_n       = COL_OFF;
    if (lhbl_l && lvbl_l && !outside) begin
      if (bline == '0) begin
        b_n = COL_FULL;
      end else if (on_bar) begin
        if (!blink_off) r_n = COL_FULL;
      end else begin
        g_n = COL_FULL;
      end
    end
    if (dwnld_busy) begin
      r_n = r_n >> 1;
      g_n = g_n >> 1;
      b_n = b_n >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red     <= COL_OFF;
      green   <= COL_OFF;
      blue    <= COL_OFF;
      err_any <= 1'b0;
    end else begin
      err_any <= |sticky;
      if (pxl_cen) begin
        red   <= r_n;
        green <= g_n;
        blue  <= b_n;
      end
    end
  end

endmodule
